// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: parametrised memory-game core.
// The player repeats a growing button sequence held in an internal RAM and
// then appends a new button each round. The game ends on a win (the final
// round is reached), a loss (wrong or illegal press) or a timeout loss.
//
// Optional feature macro: JOGO_MOSTRA_SEQ_EN. When it is defined, the whole
// sequence RAM[0..r] is replayed on the leds at the start of every new round.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high reset
//   jogar      start/restart request (level)
//   botoes     debounced buttons, active-high
//   limite     final round index, latched at game start
//   timeout_en enables the inactivity timeout, latched at game start
//   leds       entry currently displayed (0 when idle)
//   ganhou     win flag
//   perdeu     loss flag (wrong/illegal press or timeout)
//   timeout    high only after a timeout loss
//   pronto     high in any end state
//   rodada     current round index
//   db_estado  state code, for debug
//
// State table (code | name | meaning):
//   0 | INICIAL     | idle after reset, waits for jogar
//   1 | PREPARA     | latches config, seeds RAM[0], clears round
//   2 | EXIBE       | shows RAM[0] for T_EXIBE cycles
//   3 | ESPERA      | waits for the press of entry j
//   4 | COMPARA     | checks the press against RAM[j]
//   5 | PROX_JOGADA | advances j or closes the round
//   6 | ESPERA_NOVA | waits for the new entry of this round
//   7 | GRAVA       | writes the new entry to RAM[r+1]
//   8 | PROX_RODADA | r++, j=0
//   9 | MOSTRA      | replays RAM[0..r] (optional feature only)
//   A | FIM_GANHOU  | won
//   B | FIM_PERDEU  | lost by a wrong or illegal press
//   C | FIM_TIMEOUT | lost by inactivity
module jogo_memoria_param #(
  parameter int                    N_BOTOES       = 4,
  parameter int                    PROF           = 16,
  parameter int                    TIMEOUT_CICLOS = 5000,
  parameter int                    T_EXIBE        = 2000,
  parameter logic [N_BOTOES-1:0]   SEMENTE        = N_BOTOES'(1),
  localparam int                   AW             = $clog2(PROF)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [AW-1:0]       limite,
  input  logic                timeout_en,
  output logic [N_BOTOES-1:0] leds,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic                pronto,
  output logic [AW-1:0]       rodada,
  output logic [3:0]          db_estado
);

  localparam int EW = $clog2(T_EXIBE + 1);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    EXIBE       = 4'h2,
    ESPERA      = 4'h3,
    COMPARA     = 4'h4,
    PROX_JOGADA = 4'h5,
    ESPERA_NOVA = 4'h6,
    GRAVA       = 4'h7,
    PROX_RODADA = 4'h8,
`ifdef JOGO_MOSTRA_SEQ_EN
    MOSTRA      = 4'h9,
`endif
    FIM_GANHOU  = 4'hA,
    FIM_PERDEU  = 4'hB,
    FIM_TIMEOUT = 4'hC
  } estado_t;

  estado_t estado, prox;

  logic [N_BOTOES-1:0] mem [PROF];
  logic [N_BOTOES-1:0] jogada;
  logic                or_prev;
  logic                evento;
  logic                em_espera;
  logic [AW-1:0]       r, j, lim;
  logic                ten;
  logic [EW-1:0]       cnt_ex;
  logic [TW-1:0]       cnt_to;
`ifdef JOGO_MOSTRA_SEQ_EN
  logic [AW-1:0]       k;
  logic                gap;
`endif

  // A press is the rising edge of "any button down"; holding gives one event.
  assign evento    = (|botoes) & ~or_prev;
  assign em_espera = (estado == ESPERA) || (estado == ESPERA_NOVA);

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:     if (jogar) prox = PREPARA;
      PREPARA:     prox = EXIBE;
      EXIBE:       if (cnt_ex == '0) prox = ESPERA;
      ESPERA: begin
        // A press in the expiry cycle wins over the timeout.
        if (evento)                    prox = COMPARA;
        else if (ten && cnt_to == '0)  prox = FIM_TIMEOUT;
      end
      COMPARA: begin
        if (!$onehot(jogada) || jogada != mem[j]) prox = FIM_PERDEU;
        else                                      prox = PROX_JOGADA;
      end
      PROX_JOGADA: begin
        if (j == r) prox = (r == lim) ? FIM_GANHOU : ESPERA_NOVA;
        else        prox = ESPERA;
      end
      ESPERA_NOVA: begin
        if (evento)                    prox = $onehot(botoes) ? GRAVA : FIM_PERDEU;
        else if (ten && cnt_to == '0)  prox = FIM_TIMEOUT;
      end
      GRAVA:       prox = PROX_RODADA;
`ifdef JOGO_MOSTRA_SEQ_EN
      PROX_RODADA: prox = MOSTRA;
      MOSTRA:      if (!gap && cnt_ex == '0 && k == r) prox = ESPERA;
`else
      PROX_RODADA: prox = ESPERA;
`endif
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (jogar) prox = PREPARA;
      default:     prox = INICIAL;
    endcase
  end

  always_comb begin
    leds = '0;
    if (estado == EXIBE) leds = mem[0];
`ifdef JOGO_MOSTRA_SEQ_EN
    if (estado == MOSTRA && !gap) leds = mem[k];
`endif
  end

  assign ganhou    = (estado == FIM_GANHOU);
  assign perdeu    = (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
  assign timeout   = (estado == FIM_TIMEOUT);
  assign pronto    = ganhou || perdeu;
  assign rodada    = r;
  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      or_prev <= 1'b0;
      jogada  <= '0;
      r       <= '0;
      j       <= '0;
      lim     <= '0;
      ten     <= 1'b0;
      cnt_ex  <= '0;
      cnt_to  <= '0;
`ifdef JOGO_MOSTRA_SEQ_EN
      k       <= '0;
      gap     <= 1'b0;
`endif
    end else begin
      or_prev <= |botoes;
      if (em_espera && evento) jogada <= botoes;

      // Inactivity down-counter: reloaded outside the wait states and on
      // every press, so it restarts on entry to ESPERA/ESPERA_NOVA.
      if (!em_espera || evento)  cnt_to <= TW'(TIMEOUT_CICLOS - 1);
      else if (cnt_to != '0)     cnt_to <= cnt_to - 1'b1;

      case (estado)
        PREPARA: begin
          // limite is AW bits wide and PROF is a power of two, so it can
          // never exceed PROF-1; latching it is the clamp.
          lim    <= limite;
          ten    <= timeout_en;
          r      <= '0;
          j      <= '0;
          cnt_ex <= EW'(T_EXIBE - 1);
        end
        EXIBE:       if (cnt_ex != '0) cnt_ex <= cnt_ex - 1'b1;
        PROX_JOGADA: if (j != r) j <= j + 1'b1;
        PROX_RODADA: begin
          r      <= r + 1'b1;
          j      <= '0;
`ifdef JOGO_MOSTRA_SEQ_EN
          k      <= '0;
          gap    <= 1'b0;
          cnt_ex <= EW'(T_EXIBE - 1);
`endif
        end
`ifdef JOGO_MOSTRA_SEQ_EN
        MOSTRA: begin
          if (gap) begin
            gap    <= 1'b0;
            k      <= k + 1'b1;
            cnt_ex <= EW'(T_EXIBE - 1);
          end else if (cnt_ex == '0) begin
            gap    <= 1'b1;
          end else begin
            cnt_ex <= cnt_ex - 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Sequence RAM is deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (estado == PREPARA)    mem[0]         <= SEMENTE;
      else if (estado == GRAVA) mem[r + 1'b1]  <= jogada;
    end
  end

endmodule

// File: tb/tb_jogo_memoria_param.sv
module tb_jogo_memoria_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic [3:0] botoes;
  logic [3:0] limite;
  logic       timeout_en;
  logic [3:0] leds;
  logic       ganhou, perdeu, timeout, pronto;
  logic [3:0] rodada;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  jogo_memoria_param #(
    .N_BOTOES(4), .PROF(16), .TIMEOUT_CICLOS(100), .T_EXIBE(10), .SEMENTE(4'b0001)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .limite(limite), .timeout_en(timeout_en), .leds(leds),
    .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .pronto(pronto),
    .rodada(rodada), .db_estado(db_estado)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  logic [3:0] exp_mem [16];
  int         mr, mlim;
  logic [3:0] exp_st_q [$];
  logic [3:0] exp_led_q [$];
  logic [3:0] last_imm;
  int         last_steps;

  function automatic bit is_onehot(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; jogar = 1'b0; botoes = 4'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic start(input logic [3:0] lim, input logic ten);
    jogar = 1'b1; limite = lim; timeout_en = ten;
    step();
    jogar = 1'b0;
    mlim = lim; mr = 0; exp_mem[0] = 4'b0001;
  endtask

  // Waits (bounded) until the game is waiting for a press or has ended.
  task automatic settle();
    bit ok;
    ok = 1'b0;
    last_steps = 0;
    for (int c = 0; c < 600; c++) begin
      if (db_estado inside {4'h3, 4'h6, 4'hA, 4'hB, 4'hC}) begin ok = 1'b1; break; end
      step();
      last_steps++;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL settle: state stuck at %h, required one of 3/6/A/B/C", db_estado);
    end
  endtask

  task automatic drive_press(input logic [3:0] v);
    botoes = v;
    step();
    last_imm = db_estado;
    botoes = 4'b0;
    settle();
  endtask

  task automatic replay(input int i, input logic [3:0] v);
    logic [3:0] e;
    if (!is_onehot(v) || v !== exp_mem[i]) e = 4'hB;
    else if (i < mr)                       e = 4'h3;
    else if (mr == mlim)                   e = 4'hA;
    else                                   e = 4'h6;
    exp_st_q.push_back(e);
    drive_press(v);
  endtask

  task automatic new_entry(input logic [3:0] v);
    if (is_onehot(v)) begin
      exp_mem[mr + 1] = v;
      mr++;
      exp_st_q.push_back(4'h3);
    end else begin
      exp_st_q.push_back(4'hB);
    end
    drive_press(v);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({db_estado, leds, ganhou, perdeu, timeout, pronto, rodada} !== 16'h0)
      $display("FAIL reset: state=%h leds=%b g=%b p=%b t=%b pr=%b rod=%0d required all 0",
               db_estado, leds, ganhou, perdeu, timeout, pronto, rodada);
    else n_pass++;
  endtask

  task automatic test_exibe();
    logic [3:0] e;
    start(4'd3, 1'b0);
    n_total++;
    if (db_estado !== 4'h1) $display("FAIL prepara: state=%h required 1", db_estado);
    else n_pass++;
    for (int i = 0; i < 10; i++) exp_led_q.push_back(4'b0001);
    exp_led_q.push_back(4'b0000);
    while (exp_led_q.size() > 0) begin
      step();
      e = exp_led_q.pop_front();
      n_total++;
      if (leds !== e) $display("FAIL exibe_leds: leds=%b required %b", leds, e);
      else n_pass++;
    end
    n_total++;
    if (db_estado !== 4'h3) $display("FAIL exibe_end: state=%h required 3", db_estado);
    else n_pass++;
  endtask

  task automatic test_win();
    logic [3:0] seq [4];
    logic [3:0] e;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    for (int rr = 0; rr <= 3; rr++) begin
      for (int i = 0; i <= rr; i++) begin
        replay(i, seq[i]);
        e = exp_st_q.pop_front();
        n_total++;
        if (db_estado !== e) $display("FAIL win_replay r%0d i%0d: state=%h required %h", rr, i, db_estado, e);
        else n_pass++;
      end
      if (rr < 3) begin
        new_entry(seq[rr + 1]);
        e = exp_st_q.pop_front();
        n_total++;
        if (db_estado !== e || rodada !== 4'(mr))
          $display("FAIL win_new r%0d: state=%h rod=%0d required %h rod=%0d", rr, db_estado, rodada, e, mr);
        else n_pass++;
      end
    end
    n_total++;
    if ({ganhou, pronto, perdeu, timeout, rodada, leds} !== {4'b1100, 4'd3, 4'b0})
      $display("FAIL win_flags: g=%b pr=%b p=%b t=%b rod=%0d leds=%b required 1 1 0 0 3 0000",
               ganhou, pronto, perdeu, timeout, rodada, leds);
    else n_pass++;
  endtask

  task automatic test_loss();
    logic [3:0] e;
    start(4'd3, 1'b0);
    n_total++;
    if (db_estado !== 4'h1 || ganhou !== 1'b0 || pronto !== 1'b0)
      $display("FAIL restart: state=%h g=%b pr=%b required 1 0 0", db_estado, ganhou, pronto);
    else n_pass++;
    settle();
    replay(0, 4'b0001);
    new_entry(4'b0010);
    replay(0, 4'b0001);
    replay(1, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      e = exp_st_q.pop_front();
      if (i == 3) begin
        n_total++;
        if (db_estado !== e || last_imm !== 4'h4 || last_steps != 1)
          $display("FAIL loss: state=%h imm=%h steps=%0d required %h 4 1", db_estado, last_imm, last_steps, e);
        else n_pass++;
      end
    end
    n_total++;
    if ({ganhou, perdeu, pronto, timeout} !== 4'b0110)
      $display("FAIL loss_flags: g=%b p=%b pr=%b t=%b required 0 1 1 0", ganhou, perdeu, pronto, timeout);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [3:0] e;
    bit early;
    start(4'd3, 1'b1);
    settle();
    replay(0, 4'b0001);
    e = exp_st_q.pop_front();
    n_total++;
    if (db_estado !== e) $display("FAIL to_enter: state=%h required %h", db_estado, e);
    else n_pass++;
    early = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (c < 100 && db_estado !== 4'h6) early = 1'b1;
    end
    n_total++;
    if (early || db_estado !== 4'hC || timeout !== 1'b1 || perdeu !== 1'b1)
      $display("FAIL timeout: early=%b state=%h t=%b p=%b required 0 C 1 1", early, db_estado, timeout, perdeu);
    else n_pass++;
  endtask

  task automatic test_no_timeout();
    logic [3:0] e;
    bit left;
    start(4'd3, 1'b0);
    settle();
    replay(0, 4'b0001);
    e = exp_st_q.pop_front();
    n_total++;
    if (db_estado !== e) $display("FAIL nto_enter: state=%h required %h", db_estado, e);
    else n_pass++;
    left = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (db_estado !== 4'h6 || timeout !== 1'b0) left = 1'b1;
    end
    n_total++;
    if (left) $display("FAIL no_timeout: state=%h t=%b required 6 0", db_estado, timeout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    new_entry(4'b0010);
    e = exp_st_q.pop_front();
    n_total++;
    if (db_estado !== e || rodada !== 4'd1)
      $display("FAIL mid_round: state=%h rod=%0d required %h 1", db_estado, rodada, e);
    else n_pass++;
    reset = 1'b1;
    jogar = 1'b1;
    step();
    reset = 1'b0;
    jogar = 1'b0;
    n_total++;
    if ({db_estado, leds, ganhou, perdeu, timeout, pronto, rodada} !== 16'h0)
      $display("FAIL reset_mid: state=%h leds=%b g=%b p=%b t=%b pr=%b rod=%0d required all 0",
               db_estado, leds, ganhou, perdeu, timeout, pronto, rodada);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [3:0] e;
    start(4'd3, 1'b0);
    settle();
    replay(0, 4'b0011);
    e = exp_st_q.pop_front();
    n_total++;
    if (db_estado !== e || perdeu !== 1'b1)
      $display("FAIL illegal: state=%h p=%b required %h 1", db_estado, perdeu, e);
    else n_pass++;
  endtask

  task automatic test_limite0();
    logic [3:0] e;
    start(4'd0, 1'b0);
    settle();
    replay(0, 4'b0001);
    e = exp_st_q.pop_front();
    n_total++;
    if (db_estado !== e || ganhou !== 1'b1 || rodada !== 4'd0)
      $display("FAIL limite0: state=%h g=%b rod=%0d required %h 1 0", db_estado, ganhou, rodada, e);
    else n_pass++;
  endtask

`ifdef JOGO_MOSTRA_SEQ_EN
  task automatic test_mostra();
    logic [3:0] e;
    bit ok;
    start(4'd3, 1'b0);
    settle();
    replay(0, 4'b0001);
    new_entry(4'b0010);
    replay(0, 4'b0001);
    replay(1, 4'b0010);
    exp_st_q.delete();
    botoes = 4'b0100;
    step();
    botoes = 4'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (db_estado === 4'h9) begin ok = 1'b1; break; end
      step();
    end
    n_total++;
    if (!ok) $display("FAIL mostra_enter: state=%h required 9", db_estado);
    else n_pass++;
    for (int i = 0; i < 10; i++) exp_led_q.push_back(4'b0001);
    exp_led_q.push_back(4'b0000);
    for (int i = 0; i < 10; i++) exp_led_q.push_back(4'b0010);
    exp_led_q.push_back(4'b0000);
    for (int i = 0; i < 10; i++) exp_led_q.push_back(4'b0100);
    while (exp_led_q.size() > 0) begin
      e = exp_led_q.pop_front();
      n_total++;
      if (leds !== e) $display("FAIL mostra_leds: leds=%b required %b", leds, e);
      else n_pass++;
      step();
    end
    n_total++;
    if (db_estado !== 4'h3 || leds !== 4'b0)
      $display("FAIL mostra_end: state=%h leds=%b required 3 0000", db_estado, leds);
    else n_pass++;
  endtask
`endif

  initial begin
    reset = 1'b1; jogar = 1'b0; botoes = 4'b0; limite = 4'd0; timeout_en = 1'b0;
    test_reset();
    test_exibe();
    test_win();
    test_loss();
    test_timeout();
    test_no_timeout();
    test_reset_mid();
    test_illegal();
    test_limite0();
`ifdef JOGO_MOSTRA_SEQ_EN
    test_mostra();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
